// File: rtl/sys_bus_pkg.sv
// Shared encodings and constants for the two-master system bus arbiter.
// BUS_ERR_DATA is returned on a watchdog-forced completion (BUS_TIMEOUT_EN builds).
package sys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  // Watchdog counter width: just wide enough for the limit, kept within 8..16 bits.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the
// master that did not own the bus last. Purely combinational.
module rr_arb2
  import sys_bus_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_e       last_grant,
  output gnt_e       grant
);

  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_M0;
      2'b10:   grant = GNT_M1;
      2'b11:   grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master / one-slave valid-ready bus arbiter (IDLE -> BUSY -> TURN).
// Optional slave-response watchdog and sticky bus_err enabled by BUS_TIMEOUT_EN.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                sys_clk,
  input  logic                sys_resetn,

  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,

  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,

  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,

  output logic [1:0]          grant
`ifdef BUS_TIMEOUT_EN
  ,
  output logic                bus_err
`endif
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sys_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e              state_q, state_d;
  gnt_e                grant_q, grant_d;
  gnt_e                last_grant_q, last_grant_d;
  logic                s_valid_q, s_valid_d;
  gnt_e                pick;
  logic                force_done;
  logic                done;
  logic [DATA_W-1:0]   resp_data;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  // Slave wins a same-cycle race with the watchdog: a real s_ready is never overridden.
  assign force_done = (state_q == BUSY) && !s_ready &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign resp_data  = force_done ? DATA_W'(BUS_ERR_DATA) : s_rdata;
  assign bus_err    = bus_err_q;

  always_comb begin
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == BUSY && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (force_done) begin
      bus_err_d = 1'b1;
    end
  end
`else
  assign force_done = 1'b0;
  assign resp_data  = s_rdata;
`endif

  assign done = (state_q == BUSY) && (s_ready || force_done);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_valid_d    = s_valid_q;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d   = pick;
          s_valid_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          last_grant_d = grant_q;
          grant_d      = GNT_NONE;
          s_valid_d    = 1'b0;
          state_d      = TURN;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        grant_d   = GNT_NONE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  // last_grant resets to m1 so that m0 takes the first tie after reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      state_q      <= IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_M1;
      s_valid_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_valid_q    <= s_valid_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  always_comb begin
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    case (grant_q)
      GNT_M0: begin
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
      GNT_M1: begin
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

  assign s_valid  = s_valid_q;
  assign grant    = grant_q;

  assign m0_ready = done && (grant_q == GNT_M0);
  assign m1_ready = done && (grant_q == GNT_M1);
  assign m0_rdata = (grant_q == GNT_M0) ? resp_data : '0;
  assign m1_rdata = (grant_q == GNT_M1) ? resp_data : '0;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: master/slave agents, a cycle-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_sys_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  typedef struct {
    logic          instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } xfer_t;

  logic          sys_clk    = 1'b0;
  logic          sys_resetn = 1'b0;
  logic          m0_valid = 1'b0, m0_instr = 1'b0;
  logic [AW-1:0] m0_addr  = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [SW-1:0] m0_wstrb = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ready;
  logic          m1_valid = 1'b0, m1_instr = 1'b0;
  logic [AW-1:0] m1_addr  = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [SW-1:0] m1_wstrb = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ready;
  logic          s_valid, s_instr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] s_rdata = '0;
  logic          s_ready = 1'b0;
  logic [1:0]    grant;
`ifdef BUS_TIMEOUT_EN
  logic          bus_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  sys_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk    (sys_clk),
    .sys_resetn (sys_resetn),
    .m0_valid   (m0_valid),
    .m0_instr   (m0_instr),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m0_ready   (m0_ready),
    .m1_valid   (m1_valid),
    .m1_instr   (m1_instr),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .m1_ready   (m1_ready),
    .s_valid    (s_valid),
    .s_instr    (s_instr),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .s_ready    (s_ready),
    .grant      (grant)
`ifdef BUS_TIMEOUT_EN
    ,
    .bus_err    (bus_err)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  xfer_t q0[$];
  xfer_t q1[$];
  bit          drv_en    = 1'b1;
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = '0;
  int          slv_cnt   = 0;
  logic        rdy0_seen = 1'b0;
  logic        rdy1_seen = 1'b0;
  bit          chk_en    = 1'b0;

  task automatic push(input int m, input logic instr, input logic [31:0] a,
                      input logic [31:0] w, input logic [3:0] s);
    xfer_t t;
    t.instr = instr; t.addr = a; t.wdata = w; t.wstrb = s;
    if (m == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  // Masters follow the hold-until-ready rule; slave answers after slv_wait cycles.
  initial begin : agents
    xfer_t t;
    forever begin
      @(posedge sys_clk);
      #1;
      if (drv_en) begin
        if (m0_valid && rdy0_seen) m0_valid = 1'b0;
        else if (!m0_valid && q0.size() > 0) begin
          t = q0.pop_front();
          m0_instr = t.instr; m0_addr = t.addr; m0_wdata = t.wdata; m0_wstrb = t.wstrb;
          m0_valid = 1'b1;
        end
        if (m1_valid && rdy1_seen) m1_valid = 1'b0;
        else if (!m1_valid && q1.size() > 0) begin
          t = q1.pop_front();
          m1_instr = t.instr; m1_addr = t.addr; m1_wdata = t.wdata; m1_wstrb = t.wstrb;
          m1_valid = 1'b1;
        end
      end
      if (s_valid) begin
        s_ready = (slv_cnt == slv_wait);
        s_rdata = s_ready ? slv_rdata : (32'h0BAD0000 | 32'(slv_cnt));
        slv_cnt++;
      end else begin
        s_ready = 1'b0;
        s_rdata = 32'h5EED5EED;
        slv_cnt = 0;
      end
    end
  end

  // Reference model: mo = owner (0 none, 1 m0, 2 m1), mturn = dead cycle pending.
  int mo = 0, mturn = 0, mlast = 2, mcnt = 0;
  bit merr = 1'b0;

  function automatic bit m_to();
`ifdef BUS_TIMEOUT_EN
    return (mo != 0) && (mcnt == TO) && !s_ready;
`else
    return 1'b0;
`endif
  endfunction

  initial begin : model
    forever begin
      @(posedge sys_clk);
      if (!sys_resetn) begin
        mo = 0; mturn = 0; mlast = 2; mcnt = 0; merr = 1'b0;
      end else if (mo != 0) begin
        if (s_ready || m_to()) begin
          if (!s_ready) merr = 1'b1;
          mlast = mo; mo = 0; mturn = 1;
        end else begin
          mcnt++;
        end
      end else if (mturn != 0) begin
        mturn = 0;
      end else begin
        mcnt = 0;
        if (m0_valid && m1_valid) mo = (mlast == 1) ? 2 : 1;
        else if (m0_valid)        mo = 1;
        else if (m1_valid)        mo = 2;
      end
    end
  end

  initial begin : compare
    bit          mto;
    logic [31:0] exp0, exp1;
    forever begin
      @(negedge sys_clk);
      rdy0_seen = m0_ready;
      rdy1_seen = m1_ready;
      if (chk_en) begin
        mto  = m_to();
        exp0 = (mo == 1) ? (mto ? 32'hDEADBEEF : s_rdata) : 32'h0;
        exp1 = (mo == 2) ? (mto ? 32'hDEADBEEF : s_rdata) : 32'h0;
        chk("grant", grant, (mo == 1) ? 2'b01 : (mo == 2) ? 2'b10 : 2'b00);
        chk("s_valid", s_valid, mo != 0);
        chk("m0_ready", m0_ready, (mo == 1) && (s_ready || mto));
        chk("m1_ready", m1_ready, (mo == 2) && (s_ready || mto));
        chk("m0_rdata", m0_rdata, exp0);
        chk("m1_rdata", m1_rdata, exp1);
        if (mo == 1) begin
          chk("s_addr0", s_addr, m0_addr);   chk("s_wdata0", s_wdata, m0_wdata);
          chk("s_wstrb0", s_wstrb, m0_wstrb); chk("s_instr0", s_instr, m0_instr);
        end else if (mo == 2) begin
          chk("s_addr1", s_addr, m1_addr);   chk("s_wdata1", s_wdata, m1_wdata);
          chk("s_wstrb1", s_wstrb, m1_wstrb); chk("s_instr1", s_instr, m1_instr);
        end
`ifdef BUS_TIMEOUT_EN
        chk("bus_err", bus_err, merr);
`endif
      end
    end
  end

  task automatic wait_quiet(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && (q0.size() != 0 || q1.size() != 0 || m0_valid || m1_valid || s_valid)) begin
      @(negedge sys_clk);
      n++;
    end
    chk(nm, n < budget, 1'b1);
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          vc, pulses, rdy_at, m1p, first_v, first_s, n, zr;
    logic [31:0] rd;
    logic [1:0]  prev_g;
    logic [1:0]  seq[8];
    int          gaps[8];

    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_en = 1'b1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_m0_ready", m0_ready, 1'b0);
    chk("rst_m1_ready", m1_ready, 1'b0);
`ifdef BUS_TIMEOUT_EN
    chk("rst_bus_err", bus_err, 1'b0);
`endif
    @(posedge sys_clk); #2 sys_resetn = 1'b1;
    @(negedge sys_clk);

    // CPU read, slave answers two cycles after s_valid
    slv_wait = 2; slv_rdata = 32'h12345678;
    push(0, 1'b0, 32'h10, 32'h0, 4'h0);
    first_v = -1; first_s = -1; pulses = 0; m1p = 0; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (m0_valid && first_v < 0) first_v = c;
      if (s_valid && first_s < 0) first_s = c;
      if (m0_ready) begin pulses++; rd = m0_rdata; end
      if (m1_ready) m1p++;
    end
    chk("t1_latency", 64'(first_s - first_v), 64'd1);
    chk("t1_pulses", pulses, 1);
    chk("t1_rdata", rd, 32'h12345678);
    chk("t1_m1_ready", m1p, 0);
    wait_quiet("t1_quiet", 50);

    // Fresh reset, then both masters request 4 transfers at once
    @(posedge sys_clk); #2 sys_resetn = 1'b0;
    @(posedge sys_clk); #2 sys_resetn = 1'b1;
    @(negedge sys_clk);
    slv_wait = 1; slv_rdata = 32'h00C0FFEE;
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0);
      push(1, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'h0);
    end
    n = 0; zr = 0; prev_g = 2'b00;
    for (int c = 0; c < 120 && n < 8; c++) begin
      @(negedge sys_clk);
      if (grant != 2'b00 && prev_g == 2'b00) begin
        seq[n] = grant; gaps[n] = zr; n++; zr = 0;
      end else if (grant == 2'b00) begin
        zr++;
      end
      prev_g = grant;
    end
    chk("t2_count", n, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < n) chk("t2_order", seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0 && i < n) chk("t2_gap", gaps[i], 2);
    end
    wait_quiet("t2_quiet", 100);

    // m1 write with three wait states
    slv_wait = 3; slv_rdata = 32'h0;
    push(1, 1'b0, 32'h100, 32'hA5A5A5A5, 4'b0011);
    vc = 0; rdy_at = -1; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge sys_clk);
      if (s_valid) begin
        chk("t3_wstrb", s_wstrb, 4'b0011);
        chk("t3_wdata", s_wdata, 32'hA5A5A5A5);
        chk("t3_addr", s_addr, 32'h100);
        if (m1_ready) begin rdy_at = vc; pulses++; end
        vc++;
      end
    end
    chk("t3_busy_cycles", vc, 4);
    chk("t3_ready_at", 64'(rdy_at), 64'd3);
    chk("t3_pulses", pulses, 1);
    wait_quiet("t3_quiet", 50);

    // Leave last owner = m0, then reset during m1's second busy cycle
    slv_wait = 0; slv_rdata = 32'h77;
    push(0, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_quiet("t4a_quiet", 50);
    slv_wait = 50;
    push(1, 1'b1, 32'h200, 32'h0, 4'h0);
    n = 0;
    while (n < 20 && !(s_valid && grant == 2'b10)) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t4_granted", n < 20, 1'b1);
    @(posedge sys_clk); #2;
    drv_en = 1'b0; sys_resetn = 1'b0; m1_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("t4_rst_s_valid", s_valid, 1'b0);
    chk("t4_rst_grant", grant, 2'b00);
    chk("t4_rst_m1_ready", m1_ready, 1'b0);
    @(posedge sys_clk); #2;
    sys_resetn = 1'b1; slv_wait = 0;
    push(0, 1'b0, 32'h30, 32'h0, 4'h0);
    push(1, 1'b0, 32'h300, 32'h0, 4'h0);
    drv_en = 1'b1;
    rd = '0; n = 0;
    while (n < 20 && grant == 2'b00) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t4_first_grant", grant, 2'b01);
    wait_quiet("t4_quiet", 50);

`ifdef BUS_TIMEOUT_EN
    // Slave never answers: watchdog forces completion at count TO
    slv_wait = 100000;
    push(0, 1'b0, 32'h50, 32'h0, 4'h0);
    vc = 0; rdy_at = -1; pulses = 0; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge sys_clk);
      if (s_valid) begin
        if (m0_ready) begin rdy_at = vc; pulses++; rd = m0_rdata; end
        vc++;
      end
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_forced_at", 64'(rdy_at), 64'(TO));
    chk("t5_rdata", rd, 32'hDEADBEEF);
    chk("t5_bus_err", bus_err, 1'b1);
    wait_quiet("t5_quiet", 50);
    slv_wait = 0; slv_rdata = 32'h11112222; rd = '0;
    push(0, 1'b0, 32'h54, 32'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (m0_ready) rd = m0_rdata;
    end
    chk("t5_next_rdata", rd, 32'h11112222);
    chk("t5_bus_err_sticky", bus_err, 1'b1);
`else
    // Slow slave: 300 wait states, no forced completion
    slv_wait = 300; slv_rdata = 32'hCAFEF00D;
    push(0, 1'b0, 32'h40, 32'h0, 4'h0);
    vc = 0; pulses = 0; rd = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk);
      if (s_valid) vc++;
      if (m0_ready) begin pulses++; rd = m0_rdata; end
    end
    chk("t5_busy_cycles", vc, 301);
    chk("t5_pulses", pulses, 1);
    chk("t5_rdata", rd, 32'hCAFEF00D);
`endif
    wait_quiet("end_quiet", 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
